// File: rtl/mmio_timer_irq_pkg.sv
// Register map and bit positions of the MMIO timer, shared by the bus decode
// and by test firmware.
package mmio_timer_irq_pkg;

    typedef enum logic [1:0] {
        REG_CTRL    = 2'd0,
        REG_COUNT   = 2'd1,
        REG_COMPARE = 2'd2,
        REG_STATUS  = 2'd3
    } reg_sel_e;

    localparam logic [3:0] OFF_CTRL    = 4'h0;
    localparam logic [3:0] OFF_COUNT   = 4'h4;
    localparam logic [3:0] OFF_COMPARE = 4'h8;
    localparam logic [3:0] OFF_STATUS  = 4'hC;

    localparam int CTRL_EN           = 0;
    localparam int CTRL_RELOAD       = 1;
    localparam int CTRL_IRQ_EN       = 2;
    localparam int CTRL_PRESCALE_LSB = 8;

    localparam int STATUS_MATCH = 0;
    localparam int STATUS_OVF   = 1;

    localparam logic [31:0] COMPARE_RESET = 32'hFFFF_FFFF;

endpackage

// File: rtl/mmio_timer_irq_prescaler.sv
// Prescaler: divides clk by PRESCALE+1 while enabled, producing a one-cycle tick.
module timer_prescaler #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  restart,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] pcnt;

    assign tick = en && (pcnt == prescale);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
        end else if (!en || restart || tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

endmodule

// File: rtl/mmio_timer_irq.sv
// Memory-mapped timer: bus decode, CTRL/COUNT/COMPARE/STATUS registers,
// count/compare logic and the one-cycle-latency read-data register.
module mmio_timer_irq
    import mmio_timer_irq_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
    parameter int          PRESCALE_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        hit,
    output logic        interrupter
);

    logic                  sel, wr, rd;
    reg_sel_e              idx;
    logic                  wr_ctrl, wr_count, wr_compare, wr_status;
    logic                  en, reload, irq_en;
    logic [PRESCALE_W-1:0] prescale;
    logic [31:0]           count, compare, count_next;
    logic                  match, ovf;
    logic                  tick, count_eq, match_set, ovf_set;
    logic [31:0]           rd_word;
    logic [31:0]           rdata_p1;
    logic                  hit_p1;
    logic                  unused_addr_lsbs;

    assign unused_addr_lsbs = ^mem_addr[1:0];

    assign sel = (mem_ren || mem_wen) && (mem_addr[31:4] == BASE_ADDR[31:4]);
    assign wr  = mem_wen && sel;
    assign rd  = mem_ren && sel;
    assign idx = reg_sel_e'(mem_addr[3:2]);

    assign wr_ctrl    = wr && (idx == REG_CTRL);
    assign wr_count   = wr && (idx == REG_COUNT);
    assign wr_compare = wr && (idx == REG_COMPARE);
    assign wr_status  = wr && (idx == REG_STATUS);

    timer_prescaler #(
        .PRESCALE_W(PRESCALE_W)
    ) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .prescale(prescale),
        .restart (wr_ctrl),
        .tick    (tick)
    );

    // A match takes precedence over overflow; RELOAD only applies on a match.
    always_comb begin
        count_eq   = (count == compare);
        match_set  = tick && count_eq;
        ovf_set    = tick && !count_eq && (&count);
        count_next = count;
        if (wr_count) begin
            count_next = mem_wdata;
        end else if (tick) begin
            count_next = (count_eq && reload) ? 32'd0 : count + 32'd1;
        end
    end

    always_comb begin
        rd_word = 32'd0;
        case (idx)
            REG_CTRL: begin
                rd_word[CTRL_EN]     = en;
                rd_word[CTRL_RELOAD] = reload;
                rd_word[CTRL_IRQ_EN] = irq_en;
                rd_word[CTRL_PRESCALE_LSB +: PRESCALE_W] = prescale;
            end
            REG_COUNT:   rd_word = count;
            REG_COMPARE: rd_word = compare;
            REG_STATUS: begin
                rd_word[STATUS_MATCH] = match;
                rd_word[STATUS_OVF]   = ovf;
            end
            default:     rd_word = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en       <= 1'b0;
            reload   <= 1'b0;
            irq_en   <= 1'b0;
            prescale <= '0;
            count    <= 32'd0;
            compare  <= COMPARE_RESET;
            match    <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                en       <= mem_wdata[CTRL_EN];
                reload   <= mem_wdata[CTRL_RELOAD];
                irq_en   <= mem_wdata[CTRL_IRQ_EN];
                prescale <= mem_wdata[CTRL_PRESCALE_LSB +: PRESCALE_W];
            end
            if (wr_compare) begin
                compare <= mem_wdata;
            end
            count <= count_next;
            // Hardware set wins over a write-1-to-clear in the same cycle.
            match <= match_set || (match && !(wr_status && mem_wdata[STATUS_MATCH]));
            ovf   <= ovf_set   || (ovf   && !(wr_status && mem_wdata[STATUS_OVF]));
        end
    end

    // Read stage: registers sampled before any same-cycle write lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_p1   <= 1'b0;
            rdata_p1 <= 32'd0;
        end else begin
            hit_p1   <= rd;
            rdata_p1 <= rd ? rd_word : 32'd0;
        end
    end

    assign hit         = hit_p1;
    assign mem_rdata   = rdata_p1;
    assign interrupter = match && irq_en;

endmodule

// File: tb/tb_mmio_timer_irq.sv
// Directed bench for mmio_timer_irq: bus access latency, counting, match,
// overflow, write collisions, disable and asynchronous reset.
module tb_mmio_timer_irq;
    import mmio_timer_irq_pkg::*;

    localparam logic [31:0] BASE = 32'hFFFF_0000;
    localparam logic [31:0] A_CTRL    = BASE + 32'(OFF_CTRL);
    localparam logic [31:0] A_COUNT   = BASE + 32'(OFF_COUNT);
    localparam logic [31:0] A_COMPARE = BASE + 32'(OFF_COMPARE);
    localparam logic [31:0] A_STATUS  = BASE + 32'(OFF_STATUS);

    logic        clk;
    logic        rst;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        hit;
    logic        interrupter;

    int nvec = 0;
    int nerr = 0;

    mmio_timer_irq #(
        .BASE_ADDR (BASE),
        .PRESCALE_W(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_ren    (mem_ren),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .hit        (hit),
        .interrupter(interrupter)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // All bus tasks start and end 1 time unit after a rising edge.
    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        mem_wen = 1'b1; mem_addr = a; mem_wdata = d;
        @(posedge clk); #1;
        mem_wen = 1'b0;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] r, output logic h);
        mem_ren = 1'b1; mem_addr = a;
        @(posedge clk); #1;
        mem_ren = 1'b0;
        r = mem_rdata;
        h = hit;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    logic [31:0] r;
    logic        h;

    initial begin
        rst = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0; mem_addr = '0; mem_wdata = '0;
        #2 rst = 1'b1;
        #1;
        chk("rst0_hit", 32'(hit), 32'd0);
        chk("rst0_rdata", mem_rdata, 32'd0);
        chk("rst0_irq", 32'(interrupter), 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Reset value of COMPARE and load latency
        bus_rd(A_COMPARE, r, h);
        chk("rst_compare", r, 32'hFFFF_FFFF);
        chk("rst_compare_hit", 32'(h), 32'd1);
        bus_wr(A_COMPARE, 32'h1234);
        bus_rd(A_COMPARE, r, h);
        chk("lat_rdata_n1", r, 32'h1234);
        chk("lat_hit_n1", 32'(h), 32'd1);
        idle(1);
        chk("lat_rdata_n2", mem_rdata, 32'd0);
        chk("lat_hit_n2", 32'(hit), 32'd0);
        bus_rd(BASE + 32'h10, r, h);
        chk("miss_rdata", r, 32'd0);
        chk("miss_hit", 32'(h), 32'd0);

        // Simultaneous load/store returns the pre-write value
        mem_ren = 1'b1; mem_wen = 1'b1; mem_addr = A_COMPARE; mem_wdata = 32'h55;
        @(posedge clk); #1;
        mem_ren = 1'b0; mem_wen = 1'b0;
        chk("rw_old", mem_rdata, 32'h1234);
        bus_rd(A_COMPARE, r, h);
        chk("rw_new", r, 32'h55);
        bus_wr(A_CTRL, 32'hFFFF_FFFE);
        bus_rd(A_CTRL, r, h);
        chk("ctrl_mask", r, 32'h0000_FF06);
        bus_wr(A_CTRL, 32'h0);

        // Match with PRESCALE=0 and RELOAD
        bus_wr(A_COMPARE, 32'd5);
        bus_wr(A_CTRL, 32'h7);
        for (int k = 0; k < 6; k++) begin
            bus_rd(A_COUNT, r, h);
            chk("m_count", r, 32'(k));
            if (k == 4) chk("m_irq_low", 32'(interrupter), 32'd0);
        end
        chk("m_irq_high", 32'(interrupter), 32'd1);
        bus_rd(A_STATUS, r, h);
        chk("m_status", r, 32'd1);
        bus_rd(A_COUNT, r, h);
        chk("m_reload", r, 32'd1);
        bus_wr(A_STATUS, 32'd1);
        chk("m_w1c_irq", 32'(interrupter), 32'd0);

        // Disable mid-count freezes COUNT
        bus_wr(A_CTRL, 32'h6);
        bus_rd(A_COUNT, r, h);
        chk("dis_count_a", r, 32'd4);
        bus_rd(A_COUNT, r, h);
        chk("dis_count_b", r, 32'd4);

        // IRQ_EN gates the interrupt line
        bus_wr(A_COUNT, 32'd7);
        bus_wr(A_COMPARE, 32'd7);
        bus_wr(A_CTRL, 32'h3);
        idle(1);
        bus_rd(A_STATUS, r, h);
        chk("gate_status", r, 32'd1);
        chk("gate_irq_off", 32'(interrupter), 32'd0);
        bus_wr(A_CTRL, 32'h6);
        chk("gate_irq_on", 32'(interrupter), 32'd1);
        bus_wr(A_STATUS, 32'd3);
        chk("gate_irq_clr", 32'(interrupter), 32'd0);
        bus_rd(A_STATUS, r, h);
        chk("gate_status_clr", r, 32'd0);

        // PRESCALE=3: one tick every 4 clocks
        bus_wr(A_COUNT, 32'd0);
        bus_wr(A_CTRL, 32'h0301);
        for (int k = 2; k <= 10; k++) begin
            bus_rd(A_COUNT, r, h);
            chk("pre_count", r, 32'((k - 2) / 4));
        end

        // Wrap from all-ones sets OVF, then COUNT==COMPARE=0 sets MATCH
        bus_wr(A_CTRL, 32'h0300);
        bus_wr(A_COUNT, 32'hFFFF_FFFE);
        bus_wr(A_COMPARE, 32'd0);
        bus_wr(A_STATUS, 32'd3);
        bus_wr(A_CTRL, 32'h0301);
        idle(8);
        bus_rd(A_STATUS, r, h);
        chk("wrap_ovf", r, 32'd2);
        bus_rd(A_COUNT, r, h);
        chk("wrap_count", r, 32'd0);
        idle(1);
        bus_rd(A_STATUS, r, h);
        chk("wrap_pre_match", r, 32'd2);
        bus_rd(A_STATUS, r, h);
        chk("wrap_match", r, 32'd3);
        bus_rd(A_COUNT, r, h);
        chk("wrap_free_run", r, 32'd1);
        chk("wrap_irq", 32'(interrupter), 32'd0);

        // Collisions: COUNT write vs tick, W1C vs new match
        bus_wr(A_CTRL, 32'h1);
        bus_wr(A_COUNT, 32'd100);
        bus_rd(A_COUNT, r, h);
        chk("col_count_wr", r, 32'd100);
        bus_rd(A_COUNT, r, h);
        chk("col_count_next", r, 32'd101);
        bus_wr(A_COMPARE, 32'd103);
        bus_wr(A_STATUS, 32'd1);
        bus_rd(A_STATUS, r, h);
        chk("col_match_kept", r, 32'd3);
        bus_wr(A_STATUS, 32'd1);
        bus_rd(A_STATUS, r, h);
        chk("col_match_clr", r, 32'd2);

        // Asynchronous reset mid-cycle with a load in flight and IRQ asserted
        bus_wr(A_CTRL, 32'h0);
        bus_wr(A_COUNT, 32'd50);
        bus_wr(A_COMPARE, 32'd50);
        bus_wr(A_CTRL, 32'h5);
        mem_ren = 1'b1; mem_addr = A_COMPARE;
        @(posedge clk); #1;
        chk("ar_pre_hit", 32'(hit), 32'd1);
        chk("ar_pre_rdata", mem_rdata, 32'd50);
        chk("ar_pre_irq", 32'(interrupter), 32'd1);
        #4 rst = 1'b1;
        #1;
        chk("ar_hit", 32'(hit), 32'd0);
        chk("ar_rdata", mem_rdata, 32'd0);
        chk("ar_irq", 32'(interrupter), 32'd0);
        #1 mem_ren = 1'b0;
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("ar_release_hit", 32'(hit), 32'd0);
        bus_rd(A_COMPARE, r, h);
        chk("ar_compare", r, 32'hFFFF_FFFF);
        bus_rd(A_CTRL, r, h);
        chk("ar_ctrl", r, 32'd0);
        bus_rd(A_COUNT, r, h);
        chk("ar_count", r, 32'd0);
        bus_rd(A_STATUS, r, h);
        chk("ar_status", r, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
